// File: rtl/glyph_plotter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : glyph_plotter
// Brief   : Rasterises one 8x16 glyph into a character cell, one pixel per
//           accepted handshake, in row-major order.
// Revision: 1.0
// ============================================================================
module glyph_plotter #(
    parameter int CELL_COLS = 40,
    parameter int CELL_ROWS = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] glyph,
    input  logic [5:0]   cell_col,
    input  logic [3:0]   cell_row,
    input  logic [2:0]   fg,
    input  logic [2:0]   bg,
    input  logic         ready,
    output logic [8:0]   x,
    output logic [7:0]   y,
    output logic [2:0]   colour,
    output logic         plot,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam logic [6:0] c_cols = 7'(CELL_COLS);
    localparam logic [4:0] c_rows = 5'(CELL_ROWS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t       r_state;
    logic [127:0] r_glyph;
    logic [5:0]   r_col;
    logic [3:0]   r_row;
    logic [2:0]   r_fg;
    logic [2:0]   r_bg;
    logic [6:0]   r_idx;

    logic         w_in_range;
    logic [6:0]   w_idx_next;
    logic [6:0]   w_bit_next;

    assign w_in_range = ({1'b0, cell_col} < c_cols) && ({1'b0, cell_row} < c_rows);
    assign w_idx_next = r_idx + 7'd1;
    // Bit 127 is the top-left pixel, so pixel i lives at bit (127 - i).
    assign w_bit_next = 7'd127 - w_idx_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_glyph <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_fg    <= '0;
            r_bg    <= '0;
            r_idx   <= '0;
            x       <= '0;
            y       <= '0;
            colour  <= '0;
            plot    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    plot <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        if (w_in_range) begin
                            r_glyph <= glyph;
                            r_col   <= cell_col;
                            r_row   <= cell_row;
                            r_fg    <= fg;
                            r_bg    <= bg;
                            r_idx   <= '0;
                            // Pixel 0 is presented straight from the request inputs.
                            x       <= {cell_col, 3'b000};
                            y       <= {cell_row, 4'b0000};
                            colour  <= glyph[127] ? fg : bg;
                            plot    <= 1'b1;
                            busy    <= 1'b1;
                            r_state <= S_DRAW;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_DRAW: begin
                    if (ready) begin
                        if (r_idx == 7'd127) begin
                            plot    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            r_idx  <= w_idx_next;
                            x      <= {r_col, w_idx_next[2:0]};
                            y      <= {r_row, w_idx_next[6:3]};
                            colour <= r_glyph[w_bit_next] ? r_fg : r_bg;
                        end
                    end
                end
                S_FIN: begin
                    busy    <= 1'b0;
                    r_idx   <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    plot    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
